// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, write-back, write-allocate L1 data cache.
// Block = 2 words. Address map: [1:0] byte (ignored), [2] word-in-block,
// [2+log2(SETS):3] index, remaining upper bits tag.
//
// Ports
//   CLK, nRST                 clock (rising edge), async active-low reset
//   dmemREN/dmemWEN           datapath read/write request (write wins)
//   dmemaddr, dmemstore       request byte address, write data
//   halt                      start flush of all dirty frames, held until reset
//   dhit, dmemload            combinational hit strobe and read data
//   flushed                   sticky flush-complete flag
//   hit_count                 saturating count of dhit cycles
//   dREN/dWEN/daddr/dstore    memory request outputs (registered)
//   dwait, dload              memory busy flag and read data
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | serve hits; start a refill on a miss, or a flush on halt
// WB0   | write back victim word 0
// WB1   | write back victim word 1
// LD0   | fetch requested block word 0
// LD1   | fetch requested block word 1, then mark frame valid/clean
// FLCHK | test frame[flush_idx] for valid & dirty
// FLWB0 | flush frame[flush_idx] word 0
// FLWB1 | flush frame[flush_idx] word 1, clear dirty
// DONE  | flush complete; no hits, no memory traffic until reset
module dcache_dm #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic [31:0] hit_count,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 29 - IDX_W;

    typedef enum logic [3:0] {
        IDLE, WB0, WB1, LD0, LD1, FLCHK, FLWB0, FLWB1, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        data_q [SETS][2];
    logic [31:0]        data_d [SETS][2];
    logic [TAG_W-1:0]   tag_q [SETS];
    logic [TAG_W-1:0]   tag_d [SETS];
    logic [SETS-1:0]    valid_q, valid_d;
    logic [SETS-1:0]    dirty_q, dirty_d;
    logic [IDX_W-1:0]   flush_idx_q, flush_idx_d;
    logic               flushed_q, flushed_d;
    logic [31:0]        hit_count_q, hit_count_d;
    logic               dren_q, dren_d;
    logic               dwen_q, dwen_d;
    logic [31:0]        daddr_q, daddr_d;
    logic [31:0]        dstore_q, dstore_d;

    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               req_word;
    logic               req;
    logic               tag_match;
    logic               unused_byte_ofs;

    assign req_idx         = dmemaddr[IDX_W+2:3];
    assign req_tag         = dmemaddr[31:IDX_W+3];
    assign req_word        = dmemaddr[2];
    assign req             = dmemREN | dmemWEN;
    assign tag_match       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign unused_byte_ofs = ^dmemaddr[1:0];

    // Hits are only served from IDLE; halt pre-empts any request.
    assign dhit     = (state_q == IDLE) && !halt && req && tag_match;
    assign dmemload = dhit ? data_q[req_idx][req_word] : 32'h0;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        tag_d       = tag_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        flush_idx_d = flush_idx_q;
        flushed_d   = flushed_q;
        hit_count_d = hit_count_q;
        dren_d      = 1'b0;
        dwen_d      = 1'b0;
        daddr_d     = 32'h0;
        dstore_d    = 32'h0;

        if (dhit && (hit_count_q != 32'hFFFF_FFFF)) begin
            hit_count_d = hit_count_q + 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = FLCHK;
                end else if (req) begin
                    if (tag_match) begin
                        if (dmemWEN) begin
                            data_d[req_idx][req_word] = dmemstore;
                            dirty_d[req_idx]          = 1'b1;
                        end
                    end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                        state_d = WB0;
                    end else begin
                        state_d = LD0;
                    end
                end
            end
            WB0: if (!dwait) state_d = WB1;
            WB1: if (!dwait) state_d = LD0;
            LD0: begin
                if (!dwait) begin
                    // Frame holds a mix of old and new words until LD1 finishes.
                    data_d[req_idx][0] = dload;
                    valid_d[req_idx]   = 1'b0;
                    state_d            = LD1;
                end
            end
            LD1: begin
                if (!dwait) begin
                    data_d[req_idx][1] = dload;
                    valid_d[req_idx]   = 1'b1;
                    dirty_d[req_idx]   = 1'b0;
                    tag_d[req_idx]     = req_tag;
                    state_d            = IDLE;
                end
            end
            FLCHK: begin
                if (valid_q[flush_idx_q] && dirty_q[flush_idx_q]) begin
                    state_d = FLWB0;
                end else if (flush_idx_q == IDX_W'(SETS - 1)) begin
                    state_d = DONE;
                end else begin
                    flush_idx_d = flush_idx_q + IDX_W'(1);
                end
            end
            FLWB0: if (!dwait) state_d = FLWB1;
            FLWB1: begin
                if (!dwait) begin
                    dirty_d[flush_idx_q] = 1'b0;
                    if (flush_idx_q == IDX_W'(SETS - 1)) begin
                        state_d = DONE;
                    end else begin
                        flush_idx_d = flush_idx_q + IDX_W'(1);
                        state_d     = FLCHK;
                    end
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase

        if (state_d == DONE) begin
            flushed_d = 1'b1;
        end

        // Bus outputs are registered from the next state so they are clean
        // and hold steady for as long as the state waits on dwait.
        case (state_d)
            WB0, WB1: begin
                dwen_d   = 1'b1;
                daddr_d  = {tag_q[req_idx], req_idx, (state_d == WB1), 2'b00};
                dstore_d = data_q[req_idx][state_d == WB1];
            end
            LD0, LD1: begin
                dren_d  = 1'b1;
                daddr_d = {req_tag, req_idx, (state_d == LD1), 2'b00};
            end
            FLWB0, FLWB1: begin
                dwen_d   = 1'b1;
                daddr_d  = {tag_q[flush_idx_d], flush_idx_d, (state_d == FLWB1), 2'b00};
                dstore_d = data_q[flush_idx_d][state_d == FLWB1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            for (int i = 0; i < SETS; i++) begin
                data_q[i][0] <= 32'h0;
                data_q[i][1] <= 32'h0;
                tag_q[i]     <= '0;
            end
            valid_q     <= '0;
            dirty_q     <= '0;
            flush_idx_q <= '0;
            flushed_q   <= 1'b0;
            hit_count_q <= 32'h0;
            dren_q      <= 1'b0;
            dwen_q      <= 1'b0;
            daddr_q     <= 32'h0;
            dstore_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            tag_q       <= tag_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            flush_idx_q <= flush_idx_d;
            flushed_q   <= flushed_d;
            hit_count_q <= hit_count_d;
            dren_q      <= dren_d;
            dwen_q      <= dwen_d;
            daddr_q     <= daddr_d;
            dstore_q    <= dstore_d;
        end
    end

    assign dREN      = dren_q;
    assign dWEN      = dwen_q;
    assign daddr     = daddr_q;
    assign dstore    = dstore_q;
    assign flushed   = flushed_q;
    assign hit_count = hit_count_q;

endmodule
